// File: rtl/instr_fetch_unit_pkg.sv
// ============================================================================
// Module   : if_pkg
// Purpose  : Shared constants and the fetch-buffer entry type for the
//            instruction fetch unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package if_pkg;

    localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/instr_fetch_unit_if.sv
// ============================================================================
// Module   : instr_fetch_unit_if
// Purpose  : ROM, redirect and decode-handshake signals of the fetch unit.
//            if_misalign exists only when FETCH_MISALIGN_CHECK_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface instr_fetch_unit_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] imem_addr;
    logic [XLEN-1:0] imem_rdata;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            if_valid;
    logic            if_ready;
    logic [31:0]     if_instr;
    logic [XLEN-1:0] if_pc;
    logic [XLEN-1:0] if_pc_plus4;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic            if_misalign;
`endif

    // Fetch-unit side
    modport master (
        output imem_addr,
        input  imem_rdata,
        input  redirect_valid,
        input  redirect_pc,
        output if_valid,
        input  if_ready,
        output if_instr,
        output if_pc,
        output if_pc_plus4
`ifdef FETCH_MISALIGN_CHECK_EN
        ,output if_misalign
`endif
    );

    // ROM / execute / decode side
    modport slave (
        input  imem_addr,
        output imem_rdata,
        output redirect_valid,
        output redirect_pc,
        input  if_valid,
        output if_ready,
        input  if_instr,
        input  if_pc,
        input  if_pc_plus4
`ifdef FETCH_MISALIGN_CHECK_EN
        ,input if_misalign
`endif
    );

endinterface

`default_nettype wire

// File: rtl/instr_fetch_unit_buffer.sv
// ============================================================================
// Module   : fetch_buffer
// Purpose  : Synchronous FIFO of {pc, instr} entries; flush beats push/pop.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_buffer
    import if_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  wire logic                      clk,
    input  wire logic                      rst,
    input  wire logic                      flush,
    input  wire logic                      push,
    input  wire logic                      pop,
    input  wire fetch_entry_t              wdata,
    output fetch_entry_t                   rdata,
    output logic [$clog2(DEPTH):0]         count,
    output logic                           full,
    output logic                           empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   c_depth   = (AW+1)'(DEPTH);
    localparam logic [AW:0]   c_cnt_one = (AW+1)'(1);
    localparam logic [AW-1:0] c_ptr_one = AW'(1);

    fetch_entry_t    r_mem [DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [AW:0]     r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (push) r_wptr <= r_wptr + c_ptr_one;
            if (pop)  r_rptr <= r_rptr + c_ptr_one;
            case ({push, pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: the head is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push && !flush) r_mem[r_wptr] <= wdata;
    end

    assign rdata = r_mem[r_rptr];
    assign count = r_count;
    assign full  = (r_count == c_depth);
    assign empty = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/instr_fetch_unit.sv
// ============================================================================
// Module   : instr_fetch_unit
// Purpose  : PC owner and prefetch stage between the instruction ROM and
//            decode. Optional feature macro: FETCH_MISALIGN_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch_unit
    import if_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int              BUF_DEPTH = 2
) (
    input  wire logic          clk,
    input  wire logic          reset,
    instr_fetch_unit_if.master bus
);

    localparam logic [XLEN-1:0] c_pc_step = XLEN'(4);

    logic [XLEN-1:0]           r_pc;
    logic                      w_push;
    logic                      w_pop;
    logic                      w_valid;
    logic                      w_stall;
    logic                      w_full;
    logic                      w_empty;
    logic [$clog2(BUF_DEPTH):0] w_count;
    logic [XLEN-1:0]           w_redirect_aligned;
    fetch_entry_t              w_wdata;
    fetch_entry_t              w_head;

    assign w_redirect_aligned = {bus.redirect_pc[XLEN-1:2], 2'b00};

    // Redirect masks the head combinationally so decode never takes a stale word.
    assign w_valid = !w_empty && !bus.redirect_valid;
    assign w_pop   = w_valid && bus.if_ready;
    assign w_push  = !bus.redirect_valid && !w_stall && (!w_full || w_pop);

    assign w_wdata.pc    = r_pc;
    assign w_wdata.instr = bus.imem_rdata;

    fetch_buffer #(
        .DEPTH (BUF_DEPTH)
    ) u_buffer (
        .clk   (clk),
        .rst   (reset),
        .flush (bus.redirect_valid),
        .push  (w_push),
        .pop   (w_pop),
        .wdata (w_wdata),
        .rdata (w_head),
        .count (w_count),
        .full  (w_full),
        .empty (w_empty)
    );

`ifdef FETCH_MISALIGN_CHECK_EN
    logic r_misalign;
    logic w_redirect_misaligned;

    assign w_redirect_misaligned = (bus.redirect_pc[1:0] != 2'b00);
    assign w_stall               = r_misalign;
    assign bus.if_misalign       = r_misalign;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                   r_misalign <= 1'b0;
        else if (bus.redirect_valid) r_misalign <= w_redirect_misaligned;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                   r_pc <= RESET_PC;
        else if (bus.redirect_valid) r_pc <= w_redirect_misaligned ? bus.redirect_pc : w_redirect_aligned;
        else if (w_push)             r_pc <= r_pc + c_pc_step;
    end
`else
    logic w_unused_lo;

    assign w_stall     = 1'b0;
    assign w_unused_lo = ^{bus.redirect_pc[1:0], w_count};

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                   r_pc <= RESET_PC;
        else if (bus.redirect_valid) r_pc <= w_redirect_aligned;
        else if (w_push)             r_pc <= r_pc + c_pc_step;
    end
`endif

    assign bus.imem_addr   = r_pc;
    assign bus.if_valid    = w_valid;
    assign bus.if_instr    = w_empty ? 32'h0     : w_head.instr;
    assign bus.if_pc       = w_empty ? XLEN'(0)  : w_head.pc;
    assign bus.if_pc_plus4 = w_empty ? XLEN'(0)  : w_head.pc + c_pc_step;

endmodule

`default_nettype wire
